// File: rtl/memory_responder.sv
// Single-port word RAM behind a valid/ready memory interface with a fixed number
// of wait states per request and an out-of-range error response.
module memory_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        memory_error,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request is taken on any rising edge where memory_valid=1 and
  // the responder is in IDLE or RESP; memory_ready pulses for exactly one cycle
  // WAIT_STATES+1 cycles later, and rdata/error are meaningful only with it.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          WORDS   = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + (33'(WORDS) << 2);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;
  logic        r_ready;
  logic        r_error;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [WORDS];

  logic                  w_accept;
  logic                  w_release;
  logic                  w_fire;
  logic                  w_use_latched;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range;
  logic                  w_do_write;
  logic                  w_do_read;
  logic                  w_unused;

  assign w_accept      = memory_valid && (r_state != S_WAIT);
  assign w_release     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_fire        = !reset && (w_release || (w_accept && NO_WAIT));

  // With no wait states the access happens on the accept edge itself, so the
  // live request inputs are used; otherwise the latched copy is.
  assign w_use_latched = (r_state == S_WAIT);
  assign w_addr        = w_use_latched ? r_addr  : memory_addr;
  assign w_wdata       = w_use_latched ? r_wdata : memory_wdata;
  assign w_wstrb       = w_use_latched ? r_wstrb : memory_wstrb;

  assign w_offset   = w_addr - BASE_ADDR;
  assign w_idx      = w_offset[DEPTH_LOG2+1:2];
  assign w_in_range = ({1'b0, w_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_addr} < LIMIT);
  assign w_do_write = w_fire && w_in_range && (w_wstrb != 4'd0);
  assign w_do_read  = w_fire && w_in_range && (w_wstrb == 4'd0);

  // The instruction tag is carried for observability only.
  assign w_unused = ^{r_instr, w_offset[1:0], w_offset[31:DEPTH_LOG2+2]};

  // RAM contents survive reset; w_fire is already gated by reset.
  always_ff @(posedge clock) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_instr <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= w_fire;
      r_error <= w_fire && !w_in_range;
      r_rdata <= w_do_read ? r_mem[w_idx] : 32'd0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (memory_valid) begin
            r_addr  <= memory_addr;
            r_wdata <= memory_wdata;
            r_wstrb <= memory_wstrb;
            r_instr <= memory_instr;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WS_LOAD;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign memory_ready = r_ready;
  assign memory_error = r_error;
  assign memory_rdata = r_rdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: four differently parameterised instances driven by
// directed steps and random traffic, checked against a word-map reference model.
module tb_memory_responder;

  localparam int          D0 = 10, D1 = 6, D2 = 8, D3 = 10;
  localparam int          WS0 = 1, WS1 = 0, WS2 = 3, WS3 = 2;
  localparam logic [31:0] B3 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_s   [4];
  logic        valid_s [4];
  logic        instr_s [4];
  logic [31:0] addr_s  [4];
  logic [31:0] wdata_s [4];
  logic [3:0]  wstrb_s [4];
  logic [31:0] rdata_s [4];
  logic        ready_s [4];
  logic        err_s   [4];
  logic [1:0]  st_s    [4];

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_LOG2(D0), .WAIT_STATES(WS0), .BASE_ADDR(32'h0)) dut0 (
    .clock(clk), .reset(rst_s[0]), .memory_valid(valid_s[0]), .memory_instr(instr_s[0]),
    .memory_addr(addr_s[0]), .memory_wdata(wdata_s[0]), .memory_wstrb(wstrb_s[0]),
    .memory_rdata(rdata_s[0]), .memory_ready(ready_s[0]), .memory_error(err_s[0]),
    .o_dbg_state(st_s[0]));
  memory_responder #(.DEPTH_LOG2(D1), .WAIT_STATES(WS1), .BASE_ADDR(32'h0)) dut1 (
    .clock(clk), .reset(rst_s[1]), .memory_valid(valid_s[1]), .memory_instr(instr_s[1]),
    .memory_addr(addr_s[1]), .memory_wdata(wdata_s[1]), .memory_wstrb(wstrb_s[1]),
    .memory_rdata(rdata_s[1]), .memory_ready(ready_s[1]), .memory_error(err_s[1]),
    .o_dbg_state(st_s[1]));
  memory_responder #(.DEPTH_LOG2(D2), .WAIT_STATES(WS2), .BASE_ADDR(32'h0)) dut2 (
    .clock(clk), .reset(rst_s[2]), .memory_valid(valid_s[2]), .memory_instr(instr_s[2]),
    .memory_addr(addr_s[2]), .memory_wdata(wdata_s[2]), .memory_wstrb(wstrb_s[2]),
    .memory_rdata(rdata_s[2]), .memory_ready(ready_s[2]), .memory_error(err_s[2]),
    .o_dbg_state(st_s[2]));
  memory_responder #(.DEPTH_LOG2(D3), .WAIT_STATES(WS3), .BASE_ADDR(B3)) dut3 (
    .clock(clk), .reset(rst_s[3]), .memory_valid(valid_s[3]), .memory_instr(instr_s[3]),
    .memory_addr(addr_s[3]), .memory_wdata(wdata_s[3]), .memory_wstrb(wstrb_s[3]),
    .memory_rdata(rdata_s[3]), .memory_ready(ready_s[3]), .memory_error(err_s[3]),
    .o_dbg_state(st_s[3]));

  function automatic int p_ws(int k);
    case (k)
      0: return WS0;
      1: return WS1;
      2: return WS2;
      default: return WS3;
    endcase
  endfunction

  function automatic int p_d(int k);
    case (k)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  function automatic logic [31:0] p_base(int k);
    return (k == 3) ? B3 : 32'h0;
  endfunction

  // Reference: in range iff base <= a < base + 4*words, evaluated without wrap.
  function automatic bit mdl_in_range(int k, logic [31:0] a);
    longint ua = longint'(a);
    longint lb = longint'(p_base(k));
    longint lim = lb + 4 * (longint'(1) << p_d(k));
    return (ua >= lb) && (ua < lim);
  endfunction

  function automatic int mdl_key(int k, logic [31:0] a);
    logic [31:0] off = a - p_base(k);
    return k * (1 << 20) + int'((off >> 2) & ((32'd1 << p_d(k)) - 32'd1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int k, output int n);
    n = 1;
    while (ready_s[k] !== 1'b1 && n < 24) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic apply_model_write(input int k, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] ws);
    logic [31:0] cur;
    int key;
    if (!mdl_in_range(k, a) || ws == 4'd0) return;
    key = mdl_key(k, a);
    cur = mdl.exists(key) ? mdl[key] : 32'h0;
    for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
    mdl[key] = cur;
  endtask

  // One request with valid dropped and inputs scrambled right after the accept edge.
  task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic ins, input string tag);
    bit          exp_err = !mdl_in_range(k, a);
    bit          known = 1'b1;
    logic [31:0] exp_rd = 32'h0;
    int          n;
    int          key = mdl_key(k, a);
    if (!exp_err && ws == 4'd0) begin
      if (mdl.exists(key)) exp_rd = mdl[key];
      else known = 1'b0;
    end
    @(negedge clk);
    valid_s[k] = 1'b1; addr_s[k] = a; wdata_s[k] = wd; wstrb_s[k] = ws; instr_s[k] = ins;
    @(posedge clk);
    @(negedge clk);
    valid_s[k] = 1'b0; addr_s[k] = $urandom; wdata_s[k] = $urandom; wstrb_s[k] = 4'($urandom);
    wait_ready(k, n);
    chk({tag, "_latency"}, 32'(n), 32'(p_ws(k) + 1));
    chk({tag, "_ready"}, 32'(ready_s[k]), 32'd1);
    chk({tag, "_error"}, 32'(err_s[k]), 32'(exp_err));
    if (known) chk({tag, "_rdata"}, rdata_s[k], exp_rd);
    apply_model_write(k, a, wd, ws);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(ready_s[k]), 32'd0);
    chk({tag, "_idle_rdata"}, rdata_s[k], 32'd0);
    chk({tag, "_idle_error"}, 32'(err_s[k]), 32'd0);
  endtask

  // Full-word write immediately followed by a read of the same word, valid held high.
  task automatic b2b(input int k, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int n;
    @(negedge clk);
    valid_s[k] = 1'b1; addr_s[k] = a; wdata_s[k] = wd; wstrb_s[k] = 4'hF; instr_s[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_ready(k, n);
    chk({tag, "_wr_latency"}, 32'(n), 32'(p_ws(k) + 1));
    chk({tag, "_wr_rdata"}, rdata_s[k], 32'd0);
    apply_model_write(k, a, wd, 4'hF);
    wstrb_s[k] = 4'h0; wdata_s[k] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    valid_s[k] = 1'b0;
    wait_ready(k, n);
    chk({tag, "_rd_latency"}, 32'(n), 32'(p_ws(k) + 1));
    chk({tag, "_rd_ready"}, 32'(ready_s[k]), 32'd1);
    chk({tag, "_rd_rdata"}, rdata_s[k], mdl[mdl_key(k, a)]);
    chk({tag, "_rd_error"}, 32'(err_s[k]), 32'd0);
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(ready_s[k]), 32'd0);
  endtask

  task automatic count_ready(input int k, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_s[k] === 1'b1) cnt++;
    end
  endtask

  initial begin
    int          n;
    int          cnt;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;

    for (int k = 0; k < 4; k++) begin
      rst_s[k] = 1'b1; valid_s[k] = 1'b0; instr_s[k] = 1'b0;
      addr_s[k] = 32'h0; wdata_s[k] = 32'h0; wstrb_s[k] = 4'h0;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_ready%0d", k), 32'(ready_s[k]), 32'd0);
      chk($sformatf("reset_rdata%0d", k), rdata_s[k], 32'd0);
      chk($sformatf("reset_error%0d", k), 32'(err_s[k]), 32'd0);
      chk($sformatf("reset_state%0d", k), 32'(st_s[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;

    // Basic write/read with one wait state, then a byte-strobe merge.
    do_req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "ws1_write");
    do_req(0, 32'h10, 32'h0, 4'h0, 1'b0, "ws1_read");
    do_req(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0, "strb_init");
    do_req(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, "strb_write");
    do_req(0, 32'h22, 32'h0, 4'h0, 1'b1, "strb_read_instr");

    // Back-to-back write then read of the same word.
    b2b(1, 32'h8, 32'h0000_0055, "b2b_ws0");
    b2b(0, 32'h44, 32'h0BAD_CAFE, "b2b_ws1");
    b2b(2, 32'h3FC, 32'h7777_1234, "b2b_ws3_top");

    // Range boundaries with a non-zero base.
    do_req(3, 32'h1000, 32'hA5A5_0001, 4'hF, 1'b0, "base_lo_wr");
    do_req(3, 32'h1FFC, 32'h5A5A_0002, 4'hF, 1'b0, "base_hi_wr");
    do_req(3, 32'h2000, 32'h0, 4'h0, 1'b0, "oor_read_hi");
    do_req(3, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, 1'b0, "oor_write_lo");
    do_req(3, 32'h1000, 32'h0, 4'h0, 1'b0, "base_lo_rd");
    do_req(3, 32'h1FFC, 32'h0, 4'h0, 1'b0, "base_hi_rd");
    do_req(0, 32'hFFFF_FFFC, 32'h1, 4'hF, 1'b0, "oor_top_of_space");

    // Reset in the middle of a write's wait period abandons it.
    do_req(2, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, "rstw_init");
    @(negedge clk);
    valid_s[2] = 1'b1; addr_s[2] = 32'h40; wdata_s[2] = 32'h1234_5678; wstrb_s[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    valid_s[2] = 1'b0;
    rst_s[2] = 1'b1;
    #1;
    chk("rstw_ready", 32'(ready_s[2]), 32'd0);
    chk("rstw_error", 32'(err_s[2]), 32'd0);
    chk("rstw_state", 32'(st_s[2]), 32'd0);
    @(negedge clk);
    rst_s[2] = 1'b0;
    count_ready(2, 8, cnt);
    chk("rstw_no_ready", 32'(cnt), 32'd0);
    do_req(2, 32'h40, 32'h0, 4'h0, 1'b0, "rstw_keep");

    // Reset while the response is on the bus removes it at once.
    @(negedge clk);
    valid_s[0] = 1'b1; addr_s[0] = 32'h10; wstrb_s[0] = 4'h0;
    @(posedge clk);
    @(negedge clk);
    valid_s[0] = 1'b0;
    wait_ready(0, n);
    chk("rstr_latency", 32'(n), 32'(WS0 + 1));
    rst_s[0] = 1'b1;
    #1;
    chk("rstr_ready", 32'(ready_s[0]), 32'd0);
    chk("rstr_rdata", rdata_s[0], 32'd0);
    @(negedge clk);
    rst_s[0] = 1'b0;
    count_ready(0, 6, cnt);
    chk("rstr_no_ready", 32'(cnt), 32'd0);

    // Random traffic over a pre-initialised window plus out-of-range hits.
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 16; w++)
        do_req(k, p_base(k) + 32'(w * 4), $urandom, 4'hF, 1'b0, $sformatf("init%0d_%0d", k, w));
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          a = p_base(k) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        end else if (p_base(k) != 32'h0 && $urandom_range(0, 1) == 1) begin
          a = p_base(k) - 32'd4 - 32'($urandom_range(0, 255) * 4);
        end else begin
          a = p_base(k) + (32'd4 << p_d(k)) + 32'($urandom_range(0, 255) * 4);
        end
        wd = $urandom;
        ws = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        do_req(k, a, wd, ws, 1'($urandom), $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
